moller_adc_err_stats: RTL and testbench
=======================================

// Module: moller_adc_err_stats
// PURPOSE
//  Parametrised per-channel ADC link-error statistics block; successor to the fixed 16-channel
//  bad_pattern/bad_dco counter array. Counts pattern and DCO errors per channel with saturation,
//  sticky overflow flags, masked clear, and an atomic snapshot (manual or periodic).
//  Software reads coherent counts from the snapshot through an indexed read port
//  driven by the register-map glue.
// PARAMETERS
//  NUM_CH       16  number of ADC channels (1..64)
//  CNT_W        16  width of each error counter (2..32)
//  SNAP_PERIOD  0   auto-snapshot interval in clocks; 0 disables auto-snapshot
//  IDX_W        $clog2(NUM_CH) (min 1)  width of rd_idx
// PORTS
//  axi_aclk     in   1            clock
//  axi_aresetn  in   1            asynchronous active-low reset
//  pattern_err  in   NUM_CH       per-channel test-pattern mismatch strobe, 1 per cycle
//  dco_err      in   NUM_CH       per-channel DCO error strobe, 1 per cycle
//  clear        in   1            single-cycle pulse: clear counters of masked channels
//  clear_mask   in   NUM_CH       channels affected by clear (1 = clear)
//  snap_req     in   1            single-cycle pulse: copy live counters to snapshot
//  rd_req       in   1            read request for snapshot entry rd_idx
//  rd_idx       in   IDX_W        channel index to read
//  rd_valid     out  1            read data valid, one cycle after rd_req
//  rd_data      out  2*CNT_W      {dco_cnt, pattern_cnt} of snapshot entry
//  rd_ovf       out  2            {dco_ovf, pattern_ovf} sticky flags of snapshot entry
//  rd_err       out  1            rd_idx >= NUM_CH on the returned read
//  ovf_any      out  1            OR of all live overflow flags
//  snap_count   out  16           number of snapshots taken, wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Reset: all live/snapshot counters, ovf flags, period counter, snap_count = 0;
//    rd_valid, rd_data, rd_ovf, rd_err, ovf_any = 0.
//  - Counting: on each edge, live cnt += 1 when its strobe is high. At 2^CNT_W-1 the counter holds
//    (saturates) and its sticky ovf flag sets; ovf never sets before the counter is full.
//  - Clear: clear=1 zeroes counter and ovf of every channel with clear_mask=1 on that edge.
//    Clear + strobe same cycle -> counter = 0 (clear wins, the event is dropped).
//    Unmasked channels count normally.
//  - Snapshot trigger = snap_req | auto tick. Auto tick: period counter counts 0..SNAP_PERIOD-1 and
//    ticks on the wrap; snap_req restarts it at 0. SNAP_PERIOD=0 -> no auto tick, counter held at 0.
//  - Snapshot: on trigger edge, every shadow entry <= live value as it was before that edge
//    (pre-clear, pre-increment). All channels captured on the same edge; snap_count += 1.
//    snap_req and auto tick in the same cycle count as one snapshot.
//  - Read: rd_req at cycle N -> rd_valid=1 at N+1 for exactly one cycle.
//    rd_data/rd_ovf reflect the shadow as it stood before the N edge.
//    A snapshot on the same edge is not visible until reads issued at N+1.
//    rd_req may be asserted every cycle (full throughput). rd_idx >= NUM_CH -> rd_data=0,
//    rd_ovf=0, rd_err=1. rd_data/rd_ovf/rd_err hold their last values when rd_valid=0.
//  - ovf_any is registered: it goes high on the edge after any live flag sets, and clears once
//    all live flags are cleared.
//  - Asynchronous reset mid-operation discards all state immediately. Counting resumes on the
//    first edge after deassertion (axi_aresetn is assumed synchronously deasserted upstream).
// TESTING
//  1. Reset, pattern_err[3]=1 for 5 cycles, snap_req, read idx 3
//     -> rd_data={0,5}, rd_ovf=0, snap_count=1.
//  2. CNT_W=4, dco_err[0]=1 for 20 cycles, snap, read idx 0
//     -> dco_cnt=15, rd_ovf=2'b10, ovf_any=1.
//  3. Ch1/ch2 at 7; clear with mask=0b0010 while pattern_err[1]=1 and [2]=1, snap
//     -> ch1=0, ch2=8.
//  4. Live ch0=9 and shadow ch0=4; snap_req and rd_req(idx 0) same cycle
//     -> rd_data pattern=4; next read returns 9.
//  5. SNAP_PERIOD=10, no snap_req for 35 cycles -> snap_count=3.
//     snap_req at cycle 5 -> next auto tick 10 cycles later.
//  6. NUM_CH=12, rd_idx=13 -> rd_valid=1, rd_err=1, rd_data=0.
//     Back-to-back rd_req idx 0..11 -> 12 consecutive valid cycles.

Source files
------------

// File: rtl/moller_adc_err_stats.sv
// Per-channel ADC link-error statistics: saturating pattern/DCO counters with sticky
// overflow, masked clear, atomic snapshot (manual or periodic) and an indexed read port.
module moller_adc_err_stats #(
    parameter int NUM_CH      = 16,
    parameter int CNT_W       = 16,
    parameter int SNAP_PERIOD = 0,
    parameter int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic [NUM_CH-1:0]    pattern_err,
    input  logic [NUM_CH-1:0]    dco_err,
    input  logic                 clear,
    input  logic [NUM_CH-1:0]    clear_mask,
    input  logic                 snap_req,
    input  logic                 rd_req,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [2*CNT_W-1:0]   rd_data,
    output logic [1:0]           rd_ovf,
    output logic                 rd_err,
    output logic                 ovf_any,
    output logic [15:0]          snap_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int PER_W = (SNAP_PERIOD > 1) ? $clog2(SNAP_PERIOD) : 1;

    logic [CNT_W-1:0]  pat_cnt    [NUM_CH];
    logic [CNT_W-1:0]  dco_cnt    [NUM_CH];
    logic [NUM_CH-1:0] pat_ovf;
    logic [NUM_CH-1:0] dco_ovf;

    logic [CNT_W-1:0]  sh_pat_cnt [NUM_CH];
    logic [CNT_W-1:0]  sh_dco_cnt [NUM_CH];
    logic [NUM_CH-1:0] sh_pat_ovf;
    logic [NUM_CH-1:0] sh_dco_ovf;

    logic [PER_W-1:0]  per_cnt;
    logic              auto_tick;
    logic              snap_trig;

    logic [2*CNT_W-1:0] sel_data;
    logic [1:0]         sel_ovf;
    logic               sel_hit;

    assign auto_tick = (SNAP_PERIOD != 0) && (per_cnt == PER_W'(SNAP_PERIOD - 1));
    assign snap_trig = snap_req | auto_tick;

    // Clear beats a same-cycle strobe; a strobe on a full counter only raises the sticky flag.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pat_cnt[i] <= '0;
                dco_cnt[i] <= '0;
            end
            pat_ovf <= '0;
            dco_ovf <= '0;
            ovf_any <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear && clear_mask[i]) begin
                    pat_cnt[i] <= '0;
                    dco_cnt[i] <= '0;
                    pat_ovf[i] <= 1'b0;
                    dco_ovf[i] <= 1'b0;
                end else begin
                    if (pattern_err[i]) begin
                        if (pat_cnt[i] == CNT_MAX)
                            pat_ovf[i] <= 1'b1;
                        else
                            pat_cnt[i] <= pat_cnt[i] + 1'b1;
                    end
                    if (dco_err[i]) begin
                        if (dco_cnt[i] == CNT_MAX)
                            dco_ovf[i] <= 1'b1;
                        else
                            dco_cnt[i] <= dco_cnt[i] + 1'b1;
                    end
                end
            end
            ovf_any <= |{pat_ovf, dco_ovf};
        end
    end

    // Period counter restarts on a manual snapshot so the next auto tick is a full period away.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            per_cnt <= '0;
        end else if (SNAP_PERIOD == 0 || snap_req || auto_tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_pat_cnt[i] <= '0;
                sh_dco_cnt[i] <= '0;
            end
            sh_pat_ovf <= '0;
            sh_dco_ovf <= '0;
            snap_count <= '0;
        end else if (snap_trig) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_pat_cnt[i] <= pat_cnt[i];
                sh_dco_cnt[i] <= dco_cnt[i];
            end
            sh_pat_ovf <= pat_ovf;
            sh_dco_ovf <= dco_ovf;
            snap_count <= snap_count + 16'd1;
        end
    end

    // Compare-based mux keeps out-of-range indices from ever addressing the shadow array.
    always_comb begin
        sel_data = '0;
        sel_ovf  = '0;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                sel_data = {sh_dco_cnt[i], sh_pat_cnt[i]};
                sel_ovf  = {sh_dco_ovf[i], sh_pat_ovf[i]};
                sel_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= sel_data;
                rd_ovf  <= sel_ovf;
                rd_err  <= ~sel_hit;
            end
        end
    end

endmodule

// File: tb/tb_moller_adc_err_stats.sv
// Scoreboard bench: reads push expected entries, a negedge monitor pops them on rd_valid.
module tb_moller_adc_err_stats;

    localparam int A_CH  = 12;
    localparam int A_W   = 4;
    localparam int A_IDX = 4;
    localparam int B_CH  = 16;
    localparam int B_W   = 16;

    typedef struct {
        logic [2*A_W-1:0] data;
        logic [1:0]       ovf;
        logic             err;
    } rd_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               a_rst_n, a_clear, a_snap, a_rd_req;
    logic [A_CH-1:0]    a_pat, a_dco, a_mask;
    logic [A_IDX-1:0]   a_rd_idx;
    logic               a_rd_valid, a_rd_err, a_ovf_any;
    logic [2*A_W-1:0]   a_rd_data;
    logic [1:0]         a_rd_ovf;
    logic [15:0]        a_snap_count;

    logic               b_rst_n, b_snap;
    logic               b_rd_valid, b_rd_err, b_ovf_any;
    logic [2*B_W-1:0]   b_rd_data;
    logic [1:0]         b_rd_ovf;
    logic [15:0]        b_snap_count;

    int checks   = 0;
    int failures = 0;
    int cur_run  = 0;
    int last_run = 0;
    rd_exp_t exp_q[$];
    logic [2*A_W-1:0] burst_exp [A_CH];

    moller_adc_err_stats #(.NUM_CH(A_CH), .CNT_W(A_W), .SNAP_PERIOD(0)) dut_a (
        .axi_aclk(clk), .axi_aresetn(a_rst_n),
        .pattern_err(a_pat), .dco_err(a_dco),
        .clear(a_clear), .clear_mask(a_mask), .snap_req(a_snap),
        .rd_req(a_rd_req), .rd_idx(a_rd_idx),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_ovf(a_rd_ovf), .rd_err(a_rd_err),
        .ovf_any(a_ovf_any), .snap_count(a_snap_count)
    );

    moller_adc_err_stats #(.NUM_CH(B_CH), .CNT_W(B_W), .SNAP_PERIOD(10)) dut_b (
        .axi_aclk(clk), .axi_aresetn(b_rst_n),
        .pattern_err('0), .dco_err('0),
        .clear(1'b0), .clear_mask('0), .snap_req(b_snap),
        .rd_req(1'b0), .rd_idx(4'd0),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_ovf(b_rd_ovf), .rd_err(b_rd_err),
        .ovf_any(b_ovf_any), .snap_count(b_snap_count)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises rd_req for the next edge and records what the shadow should return.
    task automatic apply_stimulus(input int idx, input logic [2*A_W-1:0] data,
                                  input logic [1:0] ovf, input logic err);
        rd_exp_t e;
        e.data = data;
        e.ovf  = ovf;
        e.err  = err;
        a_rd_req = 1'b1;
        a_rd_idx = A_IDX'(idx);
        exp_q.push_back(e);
    endtask

    task automatic do_read(input int idx, input logic [2*A_W-1:0] data,
                           input logic [1:0] ovf, input logic err);
        apply_stimulus(idx, data, ovf, err);
        step();
        a_rd_req = 1'b0;
    endtask

    task automatic pulse_snap();
        a_snap = 1'b1;
        step();
        a_snap = 1'b0;
    endtask

    always @(negedge clk) begin
        if (a_rd_valid) begin
            cur_run++;
            if (exp_q.size() == 0) begin
                check_output("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check_output("rd_data", 32'(a_rd_data), 32'(e.data));
                check_output("rd_ovf", 32'(a_rd_ovf), 32'(e.ovf));
                check_output("rd_err", 32'(a_rd_err), 32'(e.err));
            end
        end else if (cur_run != 0) begin
            last_run = cur_run;
            cur_run  = 0;
        end
    end

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_pat = '0; a_dco = '0; a_mask = '0; a_clear = 1'b0;
        a_snap = 1'b0; a_rd_req = 1'b0; a_rd_idx = '0; b_snap = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_rst_n = 1'b1;

        check_output("reset_rd_valid", 32'(a_rd_valid), 32'd0);
        check_output("reset_rd_data", 32'(a_rd_data), 32'd0);
        check_output("reset_ovf_any", 32'(a_ovf_any), 32'd0);
        check_output("reset_snap_count", 32'(a_snap_count), 32'd0);

        // Five pattern errors on channel 3
        a_pat[3] = 1'b1;
        repeat (5) step();
        a_pat = '0;
        pulse_snap();
        check_output("snap_count_1", 32'(a_snap_count), 32'd1);
        do_read(3, 8'h05, 2'b00, 1'b0);

        // DCO saturation on channel 0 (4-bit counters)
        a_dco[0] = 1'b1;
        repeat (14) step();
        check_output("ovf_any_before_full", 32'(a_ovf_any), 32'd0);
        repeat (6) step();
        a_dco = '0;
        step();
        check_output("ovf_any_set", 32'(a_ovf_any), 32'd1);
        pulse_snap();
        check_output("snap_count_2", 32'(a_snap_count), 32'd2);
        do_read(0, 8'hF0, 2'b10, 1'b0);

        // Masked clear racing strobes on channels 1 and 2
        a_pat[1] = 1'b1; a_pat[2] = 1'b1;
        repeat (7) step();
        a_clear = 1'b1; a_mask = 12'h002;
        step();
        a_clear = 1'b0; a_mask = '0; a_pat = '0;
        pulse_snap();
        do_read(1, 8'h00, 2'b00, 1'b0);
        do_read(2, 8'h08, 2'b00, 1'b0);

        // Clearing the only overflowing channel drops ovf_any one edge later
        a_clear = 1'b1; a_mask = 12'h001;
        step();
        a_clear = 1'b0; a_mask = '0;
        check_output("ovf_any_lag", 32'(a_ovf_any), 32'd1);
        step();
        check_output("ovf_any_cleared", 32'(a_ovf_any), 32'd0);

        // Read coinciding with a snapshot sees the old shadow
        a_pat[0] = 1'b1;
        repeat (4) step();
        a_pat = '0;
        pulse_snap();
        a_pat[0] = 1'b1;
        repeat (5) step();
        a_pat = '0;
        a_snap = 1'b1;
        apply_stimulus(0, 8'h04, 2'b00, 1'b0);
        step();
        a_snap = 1'b0;
        apply_stimulus(0, 8'h09, 2'b00, 1'b0);
        step();
        a_rd_req = 1'b0;
        check_output("snap_count_5", 32'(a_snap_count), 32'd5);
        step();
        check_output("hold_rd_valid", 32'(a_rd_valid), 32'd0);
        check_output("hold_rd_data", 32'(a_rd_data), 32'h09);

        // Out-of-range index, then a full-throughput burst
        do_read(13, 8'h00, 2'b00, 1'b1);
        step();
        for (int i = 0; i < A_CH; i++) burst_exp[i] = '0;
        burst_exp[0] = 8'h09;
        burst_exp[2] = 8'h08;
        burst_exp[3] = 8'h05;
        for (int i = 0; i < A_CH; i++) begin
            apply_stimulus(i, burst_exp[i], 2'b00, 1'b0);
            step();
        end
        a_rd_req = 1'b0;
        repeat (3) step();
        check_output("burst_run_length", 32'(last_run), 32'd12);

        // Asynchronous reset mid-count
        a_pat[3] = 1'b1;
        step();
        #2 a_rst_n = 1'b0;
        #1;
        check_output("async_snap_count", 32'(a_snap_count), 32'd0);
        check_output("async_rd_data", 32'(a_rd_data), 32'd0);
        a_pat = '0;
        @(negedge clk);
        a_rst_n = 1'b1;
        step();
        do_read(3, 8'h00, 2'b00, 1'b0);
        a_pat[3] = 1'b1;
        repeat (2) step();
        a_pat = '0;
        pulse_snap();
        check_output("post_reset_snap_count", 32'(a_snap_count), 32'd1);
        do_read(3, 8'h02, 2'b00, 1'b0);

        // Periodic snapshot on the second instance (period 10)
        b_rst_n = 1'b1;
        repeat (35) step();
        check_output("auto_snap_35", 32'(b_snap_count), 32'd3);
        b_snap = 1'b1;
        step();
        b_snap = 1'b0;
        check_output("manual_snap", 32'(b_snap_count), 32'd4);
        repeat (9) step();
        check_output("restart_no_tick_yet", 32'(b_snap_count), 32'd4);
        step();
        check_output("restart_tick", 32'(b_snap_count), 32'd5);
        repeat (9) step();
        b_snap = 1'b1;
        step();
        b_snap = 1'b0;
        check_output("coincident_single_snap", 32'(b_snap_count), 32'd6);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
